// File: rtl/mdu_ctrl.sv
// Multiply/divide unit for the E stage: fixed-latency mult/div sequencing,
// HI/LO ownership, mthi/mtlo writes and the D-stage stall for md-class instructions.
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_start,
    input  logic [1:0]  md_op,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        d_is_md,
    output logic        busy,
    output logic        stall_d,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;

    // Datapath on the latched operands; only sampled on the commit edge.
    logic        op_signed;
    logic        neg_a, neg_b;
    logic [63:0] prod;
    logic [31:0] mag_a, mag_b;
    logic [31:0] uquot, urem;
    logic [31:0] quot, rem;
    logic        div_zero;

    always_comb begin
        op_signed = ~op_q[0];
        // A single 64-bit multiplier serves both mult and multu via sign extension.
        prod  = {{32{op_signed & a_q[31]}}, a_q} * {{32{op_signed & b_q[31]}}, b_q};

        neg_a    = op_signed & a_q[31];
        neg_b    = op_signed & b_q[31];
        mag_a    = neg_a ? (32'd0 - a_q) : a_q;
        mag_b    = neg_b ? (32'd0 - b_q) : b_q;
        div_zero = (b_q == 32'd0);
        uquot    = div_zero ? 32'd0 : (mag_a / mag_b);
        urem     = div_zero ? 32'd0 : (mag_a % mag_b);
        // Magnitude form makes 0x80000000 / -1 fall out as 0x80000000 rem 0.
        quot     = (neg_a ^ neg_b) ? (32'd0 - uquot) : uquot;
        rem      = neg_a ? (32'd0 - urem) : urem;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;

        case (state_q)
            StIdle: begin
                if (md_start) begin
                    state_d = StRun;
                    op_d    = md_op;
                    a_d     = a;
                    b_d     = b;
                    cnt_d   = md_op[1] ? 5'(DIV_CYCLES) : 5'(MULT_CYCLES);
                    busy_d  = 1'b1;
                end else begin
                    if (wr_hi) hi_d = a;
                    if (wr_lo) lo_d = a;
                end
            end
            StRun: begin
                if (cnt_q == 5'd1) begin
                    state_d = StIdle;
                    cnt_d   = 5'd0;
                    busy_d  = 1'b0;
                    if (!op_q[1]) begin
                        hi_d = prod[63:32];
                        lo_d = prod[31:0];
                    end else if (!div_zero) begin
                        hi_d = rem;
                        lo_d = quot;
                    end
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                cnt_d   = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 5'd0;
            op_q    <= 2'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign stall_d = d_is_md & (busy_q | md_start);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed vector table with latency/stall checks, reset
// mid-operation, then randomized traffic against an arithmetic reference model.
module tb_mdu_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        md_start;
    logic [1:0]  md_op;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] a;
    logic [31:0] b;
    logic        d_is_md;
    logic        busy;
    logic        stall_d;
    logic [31:0] hi;
    logic [31:0] lo;

    int npass;
    int ntotal;

    mdu_ctrl #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .md_start(md_start),
        .md_op   (md_op),
        .wr_hi   (wr_hi),
        .wr_lo   (wr_lo),
        .a       (a),
        .b       (b),
        .d_is_md (d_is_md),
        .busy    (busy),
        .stall_d (stall_d),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // md_start must never be presented while busy; the stall exists to prevent it.
    always @(posedge clk) begin
        if (reset === 1'b1 && md_start === 1'b1 && busy === 1'b1) begin
            ntotal++;
            $display("FAIL start_while_busy: got md_start=1 busy=1, expected no overlap");
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_hilo(input logic [31:0] vh, input logic [31:0] vl);
        wr_hi = 1'b1;
        a     = vh;
        tick();
        wr_hi = 1'b0;
        check("mthi", hi, vh);
        wr_lo = 1'b1;
        a     = vl;
        tick();
        wr_lo = 1'b0;
        check("mtlo", lo, vl);
    endtask

    // Start an op with a colliding mthi/mtlo, pulse mtlo throughout RUN, and
    // check busy/stall/hold timing and the committed result.
    task automatic run_op(input vec_t v, input string tag);
        int n;
        n        = v.op[1] ? DIV_N : MULT_N;
        md_start = 1'b1;
        md_op    = v.op;
        a        = v.a;
        b        = v.b;
        wr_hi    = 1'b1;
        wr_lo    = 1'b1;
        d_is_md  = 1'b1;
        #1;
        check({tag, " stall_at_start"}, 32'(stall_d), 32'd1);
        tick();
        md_start = 1'b0;
        wr_hi    = 1'b0;
        wr_lo    = 1'b1;
        a        = 32'hDEAD;
        for (int k = 0; k < n; k++) begin
            check({tag, " busy_run"}, 32'(busy), 32'd1);
            check({tag, " stall_run"}, 32'(stall_d), 32'd1);
            check({tag, " hi_hold"}, hi, v.pre_hi);
            check({tag, " lo_hold"}, lo, v.pre_lo);
            tick();
        end
        wr_lo = 1'b0;
        check({tag, " busy_done"}, 32'(busy), 32'd0);
        check({tag, " stall_done"}, 32'(stall_d), 32'd0);
        check({tag, " hi_result"}, hi, v.exp_hi);
        check({tag, " lo_result"}, lo, v.exp_lo);
        d_is_md = 1'b0;
    endtask

    // Reference model: plain 64-bit arithmetic from the instruction definitions.
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    bit          m_busy, p_commit;
    int          m_left;

    task automatic model_compute(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] rh, output logic [31:0] rl,
                                 output bit commit);
        longint          sx, sy, q, r;
        longint unsigned ux, uy, up;
        sx     = longint'($signed(x));
        sy     = longint'($signed(y));
        ux     = {32'd0, x};
        uy     = {32'd0, y};
        commit = 1'b1;
        rh     = 32'd0;
        rl     = 32'd0;
        case (op)
            2'b00: begin
                q  = sx * sy;
                rh = q[63:32];
                rl = q[31:0];
            end
            2'b01: begin
                up = ux * uy;
                rh = up[63:32];
                rl = up[31:0];
            end
            2'b10: begin
                if (y == 32'd0) commit = 1'b0;
                else begin
                    q  = sx / sy;
                    r  = sx % sy;
                    rh = r[31:0];
                    rl = q[31:0];
                end
            end
            default: begin
                if (y == 32'd0) commit = 1'b0;
                else begin
                    up = ux / uy;
                    rl = up[31:0];
                    up = ux % uy;
                    rh = up[31:0];
                end
            end
        endcase
    endtask

    initial begin
        npass    = 0;
        ntotal   = 0;
        reset    = 1'b0;
        md_start = 1'b0;
        md_op    = 2'b00;
        wr_hi    = 1'b0;
        wr_lo    = 1'b0;
        a        = 32'd0;
        b        = 32'd0;
        d_is_md  = 1'b0;

        vecs[0] = '{2'b00, 32'hFFFFFFFD, 32'd5, 32'h11111111, 32'h22222222,
                    32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[1] = '{2'b01, 32'hFFFFFFFF, 32'd2, 32'h0, 32'h0, 32'h00000001, 32'hFFFFFFFE};
        vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'd2, 32'h3, 32'h4, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{2'b11, 32'd7, 32'd2, 32'h5, 32'h6, 32'd1, 32'd3};
        vecs[4] = '{2'b11, 32'd7, 32'd0, 32'h1234, 32'h5678, 32'h1234, 32'h5678};
        vecs[5] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h7, 32'h8, 32'h0, 32'h80000000};
        vecs[6] = '{2'b10, 32'd7, 32'hFFFFFFFE, 32'h9, 32'hA, 32'd1, 32'hFFFFFFFD};
        vecs[7] = '{2'b00, 32'h80000000, 32'h80000000, 32'hB, 32'hC, 32'h40000000, 32'h0};
        vecs[8] = '{2'b10, 32'd5, 32'd0, 32'hAAAA, 32'hBBBB, 32'hAAAA, 32'hBBBB};

        #12;
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            write_hilo(vecs[i].pre_hi, vecs[i].pre_lo);
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset three edges into a divide.
        write_hilo(32'hCAFE, 32'hBEEF);
        md_start = 1'b1;
        md_op    = 2'b10;
        a        = 32'd100;
        b        = 32'd7;
        d_is_md  = 1'b1;
        tick();
        md_start = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_hi", hi, 32'd0);
        check("midreset_lo", lo, 32'd0);
        check("midreset_stall", 32'(stall_d), 32'd0);
        #2;
        reset   = 1'b1;
        d_is_md = 1'b0;
        tick();
        check("post_reset_lo", lo, 32'd0);
        run_op('{2'b00, 32'hFFFFFFFD, 32'd5, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF1},
               "post_reset_mult");

        // Randomized traffic from a known reset state.
        reset = 1'b0;
        #1;
        reset = 1'b1;
        tick();
        m_hi   = 32'd0;
        m_lo   = 32'd0;
        m_busy = 1'b0;
        m_left = 0;
        for (int c = 0; c < 600; c++) begin
            md_start = !m_busy && ($urandom_range(0, 3) == 0);
            md_op    = 2'($urandom_range(0, 3));
            a        = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 9));
                2:       b = 32'd0 - 32'($urandom_range(1, 9));
                default: b = $urandom;
            endcase
            wr_hi   = ($urandom_range(0, 3) == 0);
            wr_lo   = ($urandom_range(0, 3) == 0);
            d_is_md = $urandom_range(0, 1) == 1;
            #1;
            check("rand_stall", 32'(stall_d), 32'(d_is_md & (m_busy | md_start)));
            @(posedge clk);
            if (!m_busy) begin
                if (md_start) begin
                    m_busy = 1'b1;
                    m_left = md_op[1] ? DIV_N : MULT_N;
                    model_compute(md_op, a, b, p_hi, p_lo, p_commit);
                end else begin
                    if (wr_hi) m_hi = a;
                    if (wr_lo) m_lo = a;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    if (p_commit) begin
                        m_hi = p_hi;
                        m_lo = p_lo;
                    end
                end
            end
            #1;
            check("rand_busy", 32'(busy), 32'(m_busy));
            check("rand_hi", hi, m_hi);
            check("rand_lo", lo, m_lo);
        end
        md_start = 1'b0;
        wr_hi    = 1'b0;
        wr_lo    = 1'b0;

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multiply/divide unit and its sequencing controller for the 5-stage MIPS pipeline, driven from the E stage.
- Executes mult/multu/div/divu over a fixed multi-cycle latency.
- Owns the HI/LO registers and serves mthi/mtlo writes.
- Generates the D-stage stall that holds any multiply/divide-class instruction while the unit is busy.

Parameters:
- MULT_CYCLES, 5, cycles from accepted start to HI/LO commit for mult/multu (legal range 1..31).
- DIV_CYCLES, 10, cycles from accepted start to HI/LO commit for div/divu (legal range 1..31).

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- md_start  in  1  E-stage instruction is mult/multu/div/divu.
- md_op  in  2  00 mult, 01 multu, 10 div, 11 divu; valid with md_start.
- wr_hi  in  1  E-stage mthi.
- wr_lo  in  1  E-stage mtlo.
- a  in  32  forwarded rs value.
- b  in  32  forwarded rt value.
- d_is_md  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- busy  out  1  operation in flight.
- stall_d  out  1  freeze PC and F/D, bubble D/E.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (reset=0, asynchronous):
  - hi=0, lo=0, busy=0; counter=0, state IDLE.
  - Takes effect immediately, including mid-operation; the pending result is discarded.
- State machine: IDLE, RUN.
- IDLE to RUN:
  - On a rising edge with md_start=1.
  - Latch md_op, a, b.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - busy=1 from this edge.
- RUN:
  - Counter decrements each edge.
  - On the edge where counter reaches 0: commit the result to hi/lo, busy=0, return to IDLE.
- Latency: start accepted at edge T → busy=1 for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES) → hi/lo updated and busy cleared at edge T+N.
- md_start while busy=1 is ignored. It cannot occur in correct operation because stall_d prevents it; the bench asserts this.
- Arithmetic:
  - mult: {hi,lo} = signed a × signed b, 64-bit.
  - multu: {hi,lo} = unsigned a × unsigned b, 64-bit.
  - div: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Division by zero: hi and lo unchanged at commit; busy timing is identical to a normal divide.
  - Signed 0x80000000 / -1: lo = 0x80000000, hi = 0.
- hi/lo keep their old values during RUN. Only the commit edge changes them.
- mthi/mtlo:
  - In IDLE with md_start=0: hi<=a on wr_hi, lo<=a on wr_lo, single cycle.
  - Ignored in RUN.
  - If md_start and wr_hi/wr_lo are asserted together, md_start wins and the write is dropped.
- stall_d = d_is_md & (busy | md_start). Purely combinational; stall_d deasserts in the same cycle busy falls.
- Read path: mfhi/mflo read hi/lo combinationally. They are covered by stall_d, so they always see the committed value.
- Outputs hi, lo and busy are registered. stall_d is the only combinational output.

Test Plan:
- mult: reset release; md_start, md_op=00, a=0xFFFFFFFD (-3), b=5 → busy=1 for 5 cycles; at T+5 hi=0xFFFFFFFF, lo=0xFFFFFFF1, busy=0.
- multu and stall:
  - multu a=0xFFFFFFFF, b=2 → at T+5 hi=0x00000001, lo=0xFFFFFFFE.
  - d_is_md=1 held throughout → stall_d=1 from cycle T through T+4, 0 at T+5.
- div and divu:
  - div a=0xFFFFFFF9 (-7), b=2 → at T+10 lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - divu a=7, b=2 → lo=3, hi=1.
- Divide by zero: after mthi a=0x1234, mtlo a=0x5678; divu a=7, b=0 → busy 10 cycles, then hi=0x1234, lo=0x5678 unchanged.
- Ignored writes: wr_lo=1, a=0xDEAD pulsed during RUN and also together with md_start → lo not written; final lo equals the operation result.
- Reset mid-op: reset=0 at T+3 of a div → immediately busy=0, hi=0, lo=0, stall_d=0; after release a new mult completes normally in 5 cycles.
